// File: rtl/qout_fifo.sv
// rtl/qout_fifo.sv - byte FIFO buffering the flipflop qout stream
// Registered read port with one-cycle valid strobe, occupancy and sticky error flags.
module qout_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           din,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             full_w, empty_w;
  logic             wr_acc, rd_acc;

  assign full_w  = (count_q == CW'(DEPTH));
  assign empty_w = (count_q == '0);

  // Acceptance is gated only by the registered count, so a full FIFO never
  // falls through and an empty FIFO never writes through.
  assign wr_acc = wr_en && !full_w;
  assign rd_acc = rd_en && !empty_w;

  always_comb begin
    wp_d         = wp_q;
    rp_d         = rp_q;
    count_d      = count_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;

    if (wr_acc) wp_d = wp_q + AW'(1);
    if (rd_acc) begin
      rp_d         = rp_q + AW'(1);
      dout_d       = mem_q[rp_q];
      dout_valid_d = 1'b1;
    end

    if (wr_acc && !rd_acc)      count_d = count_q + CW'(1);
    else if (rd_acc && !wr_acc) count_d = count_q - CW'(1);

    // A fresh error in the same cycle as clr_err keeps the flag set.
    if (wr_en && full_w)       overflow_d = 1'b1;
    else if (clr_err)          overflow_d = 1'b0;
    if (rd_en && empty_w)      underflow_d = 1'b1;
    else if (clr_err)          underflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q         <= '0;
      rp_q         <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wp_q         <= wp_d;
      rp_q         <= rp_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wp_q] <= din;
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign full       = full_w;
  assign empty      = empty_w;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_qout_fifo.sv
// tb/tb_qout_fifo.sv - directed self-checking bench for qout_fifo
module tb_qout_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] din = 8'h00;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  int errors = 0;
  int checks = 0;
  logic [7:0] expq[$];
  logic [7:0] e;

  qout_fifo #(.WIDTH(8), .DEPTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .clr_err    (clr_err),
    .dout       (dout),
    .dout_valid (dout_valid),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    // Reset held for three cycles
    repeat (3) step();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    reset = 1'b1;
    step();
    chk("rel_empty", empty, 1);
    chk("rel_full", full, 0);
    chk("rel_count", count, 0);
    chk("rel_dout", dout, 8'h00);
    chk("rel_valid", dout_valid, 0);
    chk("rel_ovf", overflow, 0);
    chk("rel_udf", underflow, 0);

    // Fill 00..07
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; din = 8'(i);
      step();
      chk("fill_count", count, i + 1);
    end
    chk("fill_full", full, 1);
    chk("fill_empty", empty, 0);

    // Overflow while full
    din = 8'hAA;
    step();
    idle();
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", count, 8);
    chk("ovf_full", full, 1);

    // Drain returns 00..07, never AA
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1;
      step();
      chk("drain_dout", dout, i);
      chk("drain_valid", dout_valid, 1);
    end
    idle();
    chk("drain_empty", empty, 1);
    chk("drain_udf", underflow, 0);
    step();
    chk("drain_valid_lo", dout_valid, 0);
    chk("drain_dout_hold", dout, 8'h07);

    clr_err = 1'b1;
    step();
    idle();
    chk("clr_ovf", overflow, 0);

    // Underflow while empty
    rd_en = 1'b1;
    step();
    idle();
    chk("udf_flag", underflow, 1);
    chk("udf_valid", dout_valid, 0);
    chk("udf_dout", dout, 8'h07);

    // New error in the same cycle as clr_err wins
    rd_en = 1'b1; clr_err = 1'b1;
    step();
    idle();
    chk("udf_clr_race", underflow, 1);
    clr_err = 1'b1;
    step();
    idle();
    chk("udf_clr", underflow, 0);

    // Simultaneous write+read while empty: write only
    wr_en = 1'b1; rd_en = 1'b1; din = 8'h5C;
    step();
    idle();
    chk("sim_empty_count", count, 1);
    chk("sim_empty_udf", underflow, 1);
    chk("sim_empty_valid", dout_valid, 0);
    rd_en = 1'b1;
    step();
    idle();
    chk("sim_empty_dout", dout, 8'h5C);
    chk("sim_empty_rvalid", dout_valid, 1);
    chk("sim_empty_count0", count, 0);
    clr_err = 1'b1;
    step();
    idle();

    // Preload 3 bytes, then 20 cycles of simultaneous write+read across wrap
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; din = 8'hA0 + 8'(i);
      expq.push_back(8'hA0 + 8'(i));
      step();
    end
    idle();
    chk("pre_count", count, 3);
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; rd_en = 1'b1; din = 8'h10 + 8'(i);
      expq.push_back(8'h10 + 8'(i));
      step();
      e = expq.pop_front();
      chk("wrap_dout", dout, e);
      chk("wrap_valid", dout_valid, 1);
      chk("wrap_count", count, 3);
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1;
      step();
      e = expq.pop_front();
      chk("tail_dout", dout, e);
    end
    idle();
    chk("tail_empty", empty, 1);
    chk("tail_errs", {overflow, underflow}, 0);

    // Reset mid-stream with count=5 and a read strobe in flight
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; din = 8'h60 + 8'(i);
      step();
    end
    idle();
    rd_en = 1'b1;
    step();
    idle();
    chk("mid_count5", count, 5);
    chk("mid_valid1", dout_valid, 1);
    #3 reset = 1'b0;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_valid", dout_valid, 0);
    chk("mid_rst_dout", dout, 8'h00);
    step();
    reset = 1'b1;
    wr_en = 1'b1; din = 8'h3C;
    step();
    idle();
    chk("post_count", count, 1);
    rd_en = 1'b1;
    step();
    idle();
    chk("post_dout", dout, 8'h3C);
    chk("post_valid", dout_valid, 1);
    chk("post_empty", empty, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
